sigmoid_inverse_search: RTL

// - Sequential inverse of the combinational sigmoid unit: given a target y, returns the 16-bit x
//   for which sigmoid(x) brackets y, i.e. a fixed-point logit.
// - Sits beside sigmoid in the activation datapath; feeds calibration and back-propagation paths

---
 rtl/sigmoid_pkg.sv | 15 +
 rtl/sigmoid.sv | 33 +++
 rtl/sigmoid_inverse_search.sv | 105 ++++++++++
 3 files changed

// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the sigmoid unit and its inverse search.
package sigmoid_pkg;
  localparam int W      = 16;
  localparam int N_ITER = W;
  localparam int K_W    = $clog2(W);

  typedef logic signed [W-1:0] x_t;
  typedef logic        [W-1:0] y_t;

  localparam y_t Y_ONE = 16'h8000;
  localparam x_t X_MIN = 16'h8000;
  localparam x_t X_MAX = 16'h7FFF;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
endpackage

// File: rtl/sigmoid.sv
// Combinational piecewise-linear sigmoid: x signed Q4.11 -> y unsigned Q1.15.
// Monotone non-decreasing, output floored at 1 LSB so it never reaches 0.
module sigmoid
  import sigmoid_pkg::*;
(
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  logic [W-1:0] mag;
  logic [W-1:0] f;
  logic [W-1:0] d;

  always_comb begin
    // 0x8000 negates to itself, which reads correctly as 32768 unsigned
    mag = x[W-1] ? (16'd0 - x) : x;
    // Middle breakpoint sits where the two slopes meet, keeping f monotone
    if (mag < 16'd2048)
      f = 16'h4000 + (mag << 2);
    else if (mag < 16'd4779)
      f = 16'h5000 + (mag << 1);
    else if (mag < 16'd10240)
      f = 16'h6C00 + (mag >> 1);
    else
      f = Y_ONE;
    d = Y_ONE - f;
    if (!x[W-1])
      y = f;
    else if (d == 16'd0)
      y = 16'd1;
    else
      y = d;
  end
endmodule

// File: rtl/sigmoid_inverse_search.sv
// Bit-serial bisection inverting sigmoid: returns the largest x with sigmoid(x) <= y.
module sigmoid_inverse_search
  import sigmoid_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic         out_sat_lo,
  output logic         out_sat_hi
);
  state_t         state_reg, state_next;
  logic [W-1:0]   y_lat_reg, y_lat_next;
  logic [W-1:0]   acc_reg, acc_next;
  logic [K_W-1:0] k_reg, k_next;
  logic [W-1:0]   out_x_reg, out_x_next;
  logic           sat_lo_reg, sat_lo_next;
  logic           sat_hi_reg, sat_hi_next;
  logic           lo_hit_reg, lo_hit_next;

  logic [W-1:0]   cand;
  logic [W-1:0]   probe_x;
  logic [W-1:0]   probe_y;
  logic [W-1:0]   acc_step;

  // Outside SEARCH the probe looks at the bottom of the range, so the
  // below-range condition can be captured together with the target.
  assign cand     = acc_reg | (16'd1 << k_reg);
  assign probe_x  = (state_reg == SEARCH) ? (cand ^ X_MIN) : X_MIN;
  assign acc_step = (probe_y <= y_lat_reg) ? cand : acc_reg;

  sigmoid u_sigmoid (
    .x (probe_x),
    .y (probe_y)
  );

  always_comb begin
    state_next  = state_reg;
    y_lat_next  = y_lat_reg;
    acc_next    = acc_reg;
    k_next      = k_reg;
    out_x_next  = out_x_reg;
    sat_lo_next = sat_lo_reg;
    sat_hi_next = sat_hi_reg;
    lo_hit_next = lo_hit_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          y_lat_next  = in_y;
          acc_next    = '0;
          k_next      = K_W'(N_ITER - 1);
          lo_hit_next = (probe_y > in_y);
          state_next  = SEARCH;
        end
      end
      SEARCH: begin
        acc_next = acc_step;
        k_next   = k_reg - 1'b1;
        if (k_reg == '0) begin
          state_next  = DONE;
          out_x_next  = acc_step ^ X_MIN;
          sat_hi_next = &acc_step;
          sat_lo_next = (acc_step == '0) && lo_hit_reg;
        end
      end
      DONE: begin
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      y_lat_reg  <= '0;
      acc_reg    <= '0;
      k_reg      <= '0;
      out_x_reg  <= '0;
      sat_lo_reg <= 1'b0;
      sat_hi_reg <= 1'b0;
      lo_hit_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      y_lat_reg  <= y_lat_next;
      acc_reg    <= acc_next;
      k_reg      <= k_next;
      out_x_reg  <= out_x_next;
      sat_lo_reg <= sat_lo_next;
      sat_hi_reg <= sat_hi_next;
      lo_hit_reg <= lo_hit_next;
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign out_x      = out_x_reg;
  assign out_sat_lo = sat_lo_reg;
  assign out_sat_hi = sat_hi_reg;
endmodule
